// File: rtl/grf_mp.sv
// rtl/grf_mp.sv - general register file with two write ports, bypass and pending scoreboard
//
// Purpose: 2**AW x DW register file with register 0 hardwired to zero.
//   Reads are combinational and see same-cycle writes (port 1 over port 0).
//   A per-register pending bit is set on issue and cleared on writeback.
//   An issue wins over a writeback to the same register in the same cycle.
//   NPEND is a registered count of the pending bits.
// Ports:
//   clk, Reset            clock, synchronous active-high reset
//   RA / RD / PEND        NRD read ports: address in, data out, pending flag out
//   WE0 / WA0 / WD0       primary writeback port
//   WE1 / WA1 / WD1       secondary writeback port (wins on address clash)
//   ISS_EN / ISS_A        issue strobe, marks ISS_A pending
//   NPEND                 number of registers currently pending
module grf_mp #(
   parameter int DW  = 32,
   parameter int AW  = 5,
   parameter int NRD = 2
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic [NRD*AW-1:0] RA,
   output logic [NRD*DW-1:0] RD,
   output logic [NRD-1:0]    PEND,
   input  logic              WE0,
   input  logic [AW-1:0]     WA0,
   input  logic [DW-1:0]     WD0,
   input  logic              WE1,
   input  logic [AW-1:0]     WA1,
   input  logic [DW-1:0]     WD1,
   input  logic              ISS_EN,
   input  logic [AW-1:0]     ISS_A,
   output logic [AW:0]       NPEND
);

   localparam int DEPTH = 2**AW;

   logic [DW-1:0]    regs [DEPTH];
   logic [DEPTH-1:0] pend_q;
   logic [DEPTH-1:0] pend_nxt;
   logic [AW:0]      npend_q;

   function automatic logic [AW:0] popcount(input logic [DEPTH-1:0] v);
      logic [AW:0] c;
      c = '0;
      for (int i = 0; i < DEPTH; i++) begin
         c = c + {{AW{1'b0}}, v[i]};
      end
      return c;
   endfunction

   // Writes clear first, then the issue sets, so a same-cycle issue keeps
   // the register pending for the newer producer.
   always_comb begin
      pend_nxt = pend_q;
      if (WE0) pend_nxt[WA0] = 1'b0;
      if (WE1) pend_nxt[WA1] = 1'b0;
      if (ISS_EN) pend_nxt[ISS_A] = 1'b1;
      pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
         pend_q  <= '0;
         npend_q <= '0;
      end else begin
         // Port 1 is written last so it wins an address clash.
         if (WE0 && (WA0 != '0)) regs[WA0] <= WD0;
         if (WE1 && (WA1 != '0)) regs[WA1] <= WD1;
         pend_q  <= pend_nxt;
         npend_q <= popcount(pend_nxt);
      end
   end

   assign NPEND = npend_q;

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] a;
      logic          hit1;
      logic          hit0;
      logic          nz;

      assign a    = RA[k*AW +: AW];
      assign nz   = (a != '0);
      // Bypass is suppressed during reset so reads show stored contents.
      assign hit1 = !Reset && WE1 && (WA1 == a);
      assign hit0 = !Reset && WE0 && (WA0 == a);

      assign RD[k*DW +: DW] = !nz  ? '0  :
                              hit1 ? WD1 :
                              hit0 ? WD0 :
                              regs[a];
      assign PEND[k] = nz && pend_q[a] && !(hit0 || hit1);
   end

endmodule

// File: tb/tb_grf_mp.sv
// tb/tb_grf_mp.sv - self-checking bench for grf_mp
module tb_grf_mp;

   logic        clk;
   logic        Reset;
   logic [9:0]  RA;
   logic [63:0] RD;
   logic [1:0]  PEND;
   logic        WE0;
   logic [4:0]  WA0;
   logic [31:0] WD0;
   logic        WE1;
   logic [4:0]  WA1;
   logic [31:0] WD1;
   logic        ISS_EN;
   logic [4:0]  ISS_A;
   logic [5:0]  NPEND;

   grf_mp #(.DW(32), .AW(5), .NRD(2)) dut (
      .clk(clk), .Reset(Reset), .RA(RA), .RD(RD), .PEND(PEND),
      .WE0(WE0), .WA0(WA0), .WD0(WD0),
      .WE1(WE1), .WA1(WA1), .WD1(WD1),
      .ISS_EN(ISS_EN), .ISS_A(ISS_A), .NPEND(NPEND)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        we0;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic        we1;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic        iss;
      logic [4:0]  issa;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic        chk;
      logic [31:0] e_rd0;
      logic [31:0] e_rd1;
      logic [1:0]  e_pend;
      logic [5:0]  e_np;
   } vec_t;

   typedef struct {
      logic [31:0] rd0;
      logic [31:0] rd1;
      logic [1:0]  pend;
      logic [5:0]  np;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[20];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Drive on the falling edge, sample 2 time units later; the rising edge
   // that commits the row happens before the next row is driven.
   task automatic run_vec(input vec_t v, input string tag);
      exp_t e;
      @(negedge clk);
      Reset  = v.rst;
      WE0    = v.we0;  WA0 = v.wa0;  WD0 = v.wd0;
      WE1    = v.we1;  WA1 = v.wa1;  WD1 = v.wd1;
      ISS_EN = v.iss;  ISS_A = v.issa;
      RA     = {v.ra1, v.ra0};
      if (v.chk) sb.push_back('{v.e_rd0, v.e_rd1, v.e_pend, v.e_np});
      #2;
      if (v.chk) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s scoreboard empty", tag);
         end else begin
            e = sb.pop_front();
            check({tag, ".rd0"},  RD[31:0],  e.rd0);
            check({tag, ".rd1"},  RD[63:32], e.rd1);
            check({tag, ".pend"}, {30'd0, PEND}, {30'd0, e.pend});
            check({tag, ".npend"}, {26'd0, NPEND}, {26'd0, e.np});
         end
      end
   endtask

   function automatic vec_t idle(input logic [4:0] ra0, input logic [4:0] ra1);
      vec_t v;
      v = '{1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
            ra0, ra1, 1'b0, 32'd0, 32'd0, 2'd0, 6'd0};
      return v;
   endfunction

   initial begin
      vec_t v;
      Reset = 1'b1; WE0 = 0; WA0 = 0; WD0 = 0; WE1 = 0; WA1 = 0; WD1 = 0;
      ISS_EN = 0; ISS_A = 0; RA = '0;
      repeat (2) @(posedge clk);

      //           rst we0 wa0    wd0           we1 wa1    wd1           iss issa   ra0    ra1    chk e_rd0         e_rd1         pend   np
      tbl[0]  = '{1, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 5'd3, 5'd7, 0, 32'h0,        32'h0,        2'b00, 6'd0};
      tbl[1]  = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 5'd3, 5'd7, 1, 32'h0,        32'h0,        2'b00, 6'd0};
      tbl[2]  = '{0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,        0, 5'd0, 5'd5, 5'd0, 1, 32'hDEADBEEF, 32'h0,        2'b00, 6'd0};
      tbl[3]  = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 5'd5, 5'd5, 1, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 6'd0};
      tbl[4]  = '{0, 1, 5'd9, 32'h1111,     1, 5'd9, 32'h2222,     0, 5'd0, 5'd9, 5'd5, 1, 32'h2222,     32'hDEADBEEF, 2'b00, 6'd0};
      tbl[5]  = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 5'd9, 5'd9, 1, 32'h2222,     32'h2222,     2'b00, 6'd0};
      tbl[6]  = '{0, 0, 5'd0, 32'h0,        1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 5'd0, 5'd0, 1, 32'h0,        32'h0,        2'b00, 6'd0};
      tbl[7]  = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd0, 5'd0, 5'd0, 1, 32'h0,        32'h0,        2'b00, 6'd0};
      tbl[8]  = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 5'd0, 5'd5, 1, 32'h0,        32'hDEADBEEF, 2'b00, 6'd0};
      tbl[9]  = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd4, 5'd4, 5'd5, 1, 32'h0,        32'hDEADBEEF, 2'b00, 6'd0};
      tbl[10] = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 5'd4, 5'd4, 1, 32'h0,        32'h0,        2'b11, 6'd1};
      tbl[11] = '{0, 1, 5'd4, 32'h44,       0, 5'd0, 32'h0,        0, 5'd0, 5'd4, 5'd5, 1, 32'h44,       32'hDEADBEEF, 2'b00, 6'd1};
      tbl[12] = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 5'd4, 5'd0, 1, 32'h44,       32'h0,        2'b00, 6'd0};
      tbl[13] = '{0, 1, 5'd4, 32'h45,       0, 5'd0, 32'h0,        1, 5'd4, 5'd4, 5'd4, 1, 32'h45,       32'h45,       2'b00, 6'd0};
      tbl[14] = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 5'd4, 5'd4, 1, 32'h45,       32'h45,       2'b11, 6'd1};
      tbl[15] = '{0, 0, 5'd0, 32'h0,        1, 5'd4, 32'h46,       0, 5'd0, 5'd4, 5'd9, 1, 32'h46,       32'h2222,     2'b00, 6'd1};
      tbl[16] = '{0, 1, 5'd2, 32'h22,       0, 5'd0, 32'h0,        1, 5'd6, 5'd0, 5'd0, 1, 32'h0,        32'h0,        2'b00, 6'd0};
      tbl[17] = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd2, 5'd2, 5'd6, 1, 32'h22,       32'h0,        2'b10, 6'd1};
      tbl[18] = '{1, 1, 5'd2, 32'h55,       0, 5'd0, 32'h0,        0, 5'd0, 5'd2, 5'd6, 1, 32'h22,       32'h0,        2'b11, 6'd2};
      tbl[19] = '{0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 5'd2, 5'd6, 1, 32'h0,        32'h0,        2'b00, 6'd0};

      // Fill the file with random contents and pending bits before the reset row.
      for (int i = 0; i < 12; i++) begin
         v = idle(5'd0, 5'd0);
         v.we0 = 1'b1; v.wa0 = 5'($urandom_range(1, 31)); v.wd0 = $urandom;
         v.we1 = 1'($urandom); v.wa1 = 5'($urandom_range(1, 31)); v.wd1 = $urandom;
         v.iss = 1'b1; v.issa = 5'($urandom_range(1, 31));
         run_vec(v, "prefill");
      end

      for (int i = 0; i < 20; i++) begin
         run_vec(tbl[i], $sformatf("row%0d", i));
      end

      // Mark every register 1..31 pending: NPEND reaches its maximum.
      for (int i = 1; i < 32; i++) begin
         v = idle(5'd0, 5'd0);
         v.iss = 1'b1; v.issa = 5'(i);
         run_vec(v, "fill");
      end
      v = idle(5'd31, 5'd1);
      v.chk = 1'b1; v.e_pend = 2'b11; v.e_np = 6'd31;
      run_vec(v, "full");

      // Re-issuing a pending register keeps the count unchanged.
      v = idle(5'd7, 5'd0);
      v.iss = 1'b1; v.issa = 5'd7;
      v.chk = 1'b1; v.e_pend = 2'b01; v.e_np = 6'd31;
      run_vec(v, "reissue");

      // Both writebacks in one cycle to different registers, both bypassed.
      v = idle(5'd1, 5'd31);
      v.we0 = 1'b1; v.wa0 = 5'd1;  v.wd0 = 32'hA1;
      v.we1 = 1'b1; v.wa1 = 5'd31; v.wd1 = 32'hB31;
      v.chk = 1'b1; v.e_rd0 = 32'hA1; v.e_rd1 = 32'hB31; v.e_pend = 2'b00; v.e_np = 6'd31;
      run_vec(v, "dual_wb");

      v = idle(5'd1, 5'd7);
      v.chk = 1'b1; v.e_rd0 = 32'hA1; v.e_pend = 2'b10; v.e_np = 6'd29;
      run_vec(v, "after_wb");

      v = idle(5'd0, 5'd0);
      v.rst = 1'b1;
      run_vec(v, "rst2");

      v = idle(5'd31, 5'd7);
      v.chk = 1'b1;
      run_vec(v, "post_rst2");

      @(posedge clk);
      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL sb_drain actual=%0d required=0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/grf_mp.md
Name: grf_mp

Overview:
- Parametrised general register file with NRD combinational read ports, two write ports and an internal write-to-read bypass.
- Carries a per-register scoreboard (pending bits) so the decode stage can detect outstanding writes without external hazard logic.
- Sits between decode (reads, issue marking) and the writeback stages: WB0 is the primary writeback and WB1 the secondary/late writeback.
- Register 0 is hardwired to zero and is never pending.

Parameters:
DW, 32, data width of each register
AW, 5, address width; depth = 2**AW registers
NRD, 2, number of read ports (>=1)

Ports:
clk  in  1  clock; all state updates on rising edge
Reset  in  1  synchronous, active-high reset
RA  in  NRD*AW  read addresses, port k at bits [k*AW +: AW]
RD  out  NRD*DW  read data, port k at bits [k*DW +: DW]
PEND  out  NRD  pending flag per read port
WE0  in  1  write enable, port 0
WA0  in  AW  write address, port 0
WD0  in  DW  write data, port 0
WE1  in  1  write enable, port 1
WA1  in  AW  write address, port 1
WD1  in  DW  write data, port 1
ISS_EN  in  1  issue strobe: mark ISS_A pending
ISS_A  in  AW  destination register being issued
NPEND  out  AW+1  count of registers currently pending

Behaviour:
- Storage: 2**AW x DW array R plus a 2**AW-bit pending vector P. Registers 0 of both R and P always read 0 and are never written.
- Reset (sync, active-high):
  - At the rising edge with Reset=1, all R and P clear to 0.
  - Writes and issues presented in that cycle are discarded.
  - After reset: every RD = 0, PEND = 0, NPEND = 0.
- Writes:
  - At the rising edge, R[WA0] <= WD0 if WE0 && WA0!=0, and R[WA1] <= WD1 if WE1 && WA1!=0.
  - If both are enabled with WA0==WA1, port 1 wins; WD0 is dropped.
  - Write latency: 1 edge.
- Reads: combinational, zero latency. For each port k, with a = RA[k]:
  - a==0 -> RD=0.
  - else if Reset==0 && WE1 && WA1==a -> RD=WD1.
  - else if Reset==0 && WE0 && WA0==a -> RD=WD0.
  - else RD=R[a].
  - Bypass therefore has the same priority as the write.
  - While Reset=1, no bypass: RD = stored value.
- Scoreboard update at the rising edge, Reset=0:
  - A write clears P[WAx] for each enabled write port.
  - ISS_EN sets P[ISS_A] (ignored if ISS_A==0).
  - An issue and a write to the same address in the same cycle: issue wins, P stays 1 (the new producer is outstanding).
  - An issue to an already-pending register: P stays 1. There is no count per register; the newest producer's write clears it.
- PEND[k] (combinational):
  - PEND[k] = P[RA[k]] && !(bypass hit on port k).
  - A read that is satisfied by a write in the same cycle is not pending.
  - RA==0 -> 0.
  - While Reset=1, PEND = P[RA[k]].
- NPEND: registered popcount of P, updated on the same edge as P. Range 0..2**AW-1, fits in AW+1 bits.
- No $display tracing in this block; commit trace is owned by the writeback stage.

Test Plan:
- Reset: Reset=1 for 1 edge after random writes; then RA={3,7} -> RD={0,0}, PEND=0, NPEND=0.
- Write/read with bypass:
  - WE0=1, WA0=5, WD0=32'hDEADBEEF, RA[0]=5 in the same cycle -> RD[0]=32'hDEADBEEF before the edge.
  - After the edge, with WE0=0 -> RD[0]=32'hDEADBEEF.
- Write conflict: WE0=WE1=1, WA0=WA1=9, WD0=32'h1111, WD1=32'h2222 -> RD(9)=32'h2222 in-cycle and after the edge.
- Register 0:
  - WE1=1, WA1=0, WD1=32'hFFFFFFFF, RA=0 -> RD=0 in-cycle and after the edge.
  - ISS_EN=1, ISS_A=0 -> NPEND stays 0.
- Scoreboard:
  - ISS_EN=1, ISS_A=4 -> next cycle RA=4 gives PEND=1, NPEND=1.
  - Then WE0=1, WA0=4 -> same-cycle PEND=0 (bypass); after the edge P[4]=0, NPEND=0.
  - Same-edge issue+write on reg 4 -> P[4]=1 after the edge, NPEND=1.
- Reset mid-operation: P[2],P[6] pending and WE0=1, WA0=2, WD0=32'h55 with Reset=1 -> no bypass (RD(2)=old value). After the edge: R[2]=0, NPEND=0, PEND=0.
